// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART ALU: opcodes, frame sizes and the
// response-packer state type.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  localparam int HDR_BYTES    = 4;
  localparam int RESULT_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY
  } resp_state_e;

  function automatic logic is_known_op(input logic [7:0] op);
    return (op == OP_ECHO) || (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/uart_resp_packer.sv
// Return-path framer: turns one accepted command (echo stream or 32-bit ALU
// result) into a byte stream for the UART transmitter.
module uart_resp_packer
  import uart_alu_pkg::*;
#(
  parameter int          SEND_HEADER = 1,
  parameter logic [15:0] MAX_LEN     = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_opcode_i,
  input  logic [15:0] cmd_len_i,
  input  logic [31:0] cmd_result_i,
  input  logic        echo_valid_i,
  output logic        echo_ready_o,
  input  logic [7:0]  echo_data_i,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        busy_o,
  output logic        bad_op_o
);

  localparam logic [1:0] HDR_LAST    = 2'(HDR_BYTES - 1);
  localparam logic [1:0] RESULT_LAST = 2'(RESULT_BYTES - 1);

  resp_state_e state;
  logic [7:0]  opcode_q;
  logic [15:0] len_q;
  logic [15:0] cnt;
  logic [31:0] result_q;
  logic [1:0]  idx;
  logic        is_echo;
  logic        tx_fire;
  logic        cmd_echo;
  logic [15:0] cmd_len_eff;

  assign cmd_echo    = (cmd_opcode_i == OP_ECHO);
  assign cmd_len_eff = !cmd_echo ? 16'(RESULT_BYTES) :
                       (cmd_len_i > MAX_LEN) ? MAX_LEN : cmd_len_i;

  assign cmd_ready_o = (state == IDLE) && !rst_i;
  assign busy_o      = (state != IDLE);
  assign tx_fire     = tx_valid_o && tx_ready_i;

  // Output byte mux; echo payload bypasses all registers.
  always_comb begin
    tx_valid_o   = 1'b0;
    tx_data_o    = 8'h00;
    echo_ready_o = 1'b0;
    case (state)
      HDR: begin
        tx_valid_o = 1'b1;
        case (idx)
          2'd0:    tx_data_o = opcode_q;
          2'd1:    tx_data_o = 8'h00;
          2'd2:    tx_data_o = len_q[7:0];
          default: tx_data_o = len_q[15:8];
        endcase
      end
      BODY: begin
        if (is_echo) begin
          if (cnt != 16'd0) begin
            tx_valid_o   = echo_valid_i;
            tx_data_o    = echo_data_i;
            echo_ready_o = tx_ready_i;
          end
        end else begin
          tx_valid_o = 1'b1;
          tx_data_o  = result_q[{idx, 3'b000} +: 8];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      opcode_q <= 8'h00;
      len_q    <= 16'd0;
      cnt      <= 16'd0;
      result_q <= 32'd0;
      idx      <= 2'd0;
      is_echo  <= 1'b0;
      bad_op_o <= 1'b0;
    end else begin
      bad_op_o <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            if (is_known_op(cmd_opcode_i)) begin
              opcode_q <= cmd_opcode_i;
              is_echo  <= cmd_echo;
              len_q    <= cmd_len_eff;
              cnt      <= cmd_len_eff;
              result_q <= cmd_result_i;
              idx      <= 2'd0;
              state    <= (SEND_HEADER != 0) ? HDR : BODY;
            end else begin
              bad_op_o <= 1'b1;
            end
          end
        end
        HDR: begin
          if (tx_fire) begin
            idx <= idx + 2'd1;
            if (idx == HDR_LAST) state <= (len_q == 16'd0) ? IDLE : BODY;
          end
        end
        BODY: begin
          if (is_echo) begin
            // A zero-length echo without header leaves here straight away.
            if (cnt == 16'd0) begin
              state <= IDLE;
            end else if (tx_fire) begin
              cnt <= cnt - 16'd1;
              if (cnt == 16'd1) state <= IDLE;
            end
          end else if (tx_fire) begin
            idx <= idx + 2'd1;
            if (idx == RESULT_LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_resp_packer.sv
// Bench for uart_resp_packer: one instance with header, one payload-only,
// directed cases followed by randomized frames against a frame model.
module tb_uart_resp_packer;
  import uart_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]  cmd_valid;
  logic [1:0]  tx_ready;
  logic [7:0]  cmd_opcode [2];
  logic [15:0] cmd_len    [2];
  logic [31:0] cmd_result [2];
  wire  [1:0]  tx_valid, cmd_ready, busy, bad_op, echo_ready;
  wire  [7:0]  tx_data0, tx_data1;
  logic        echo_valid0, echo_valid1;
  logic [7:0]  echo_data0, echo_data1;

  int checks = 0;
  int errors = 0;

  logic [7:0] got0[$], got1[$], echo_q[$], pay_q[$], exp_q[$];
  bit         efire, stall0, stall1;
  logic [7:0] hold0, hold1;
  bit [1:0]   bp_en;

  uart_resp_packer #(.SEND_HEADER(1)) u_hdr (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid[0]), .cmd_ready_o(cmd_ready[0]),
    .cmd_opcode_i(cmd_opcode[0]), .cmd_len_i(cmd_len[0]), .cmd_result_i(cmd_result[0]),
    .echo_valid_i(echo_valid0), .echo_ready_o(echo_ready[0]), .echo_data_i(echo_data0),
    .tx_valid_o(tx_valid[0]), .tx_ready_i(tx_ready[0]), .tx_data_o(tx_data0),
    .busy_o(busy[0]), .bad_op_o(bad_op[0])
  );

  uart_resp_packer #(.SEND_HEADER(0)) u_raw (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid[1]), .cmd_ready_o(cmd_ready[1]),
    .cmd_opcode_i(cmd_opcode[1]), .cmd_len_i(cmd_len[1]), .cmd_result_i(cmd_result[1]),
    .echo_valid_i(echo_valid1), .echo_ready_o(echo_ready[1]), .echo_data_i(echo_data1),
    .tx_valid_o(tx_valid[1]), .tx_ready_i(tx_ready[1]), .tx_data_o(tx_data1),
    .busy_o(busy[1]), .bad_op_o(bad_op[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected response frame, built from the opcode/length/result rules.
  task automatic add_exp(input int hdr, input logic [7:0] op, input logic [15:0] len,
                         input logic [31:0] res);
    bit echo, alu;
    logic [15:0] l;
    echo = (op == 8'hEC);
    alu  = (op == 8'hA0) || (op == 8'hA1) || (op == 8'hA2);
    if (!(echo || alu)) return;
    l = alu ? 16'd4 : len;
    if (hdr != 0) begin
      exp_q.push_back(op);
      exp_q.push_back(8'h00);
      exp_q.push_back(l[7:0]);
      exp_q.push_back(l[15:8]);
    end
    if (alu) for (int i = 0; i < 4; i++) exp_q.push_back(res[8*i +: 8]);
    else     for (int i = 0; i < int'(l); i++) exp_q.push_back(pay_q[i]);
  endtask

  task automatic compare_q(input int u);
    logic [7:0] g[$];
    if (u == 0) g = got0; else g = got1;
    check($sformatf("frame_len_u%0d", u), g.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < g.size(); i++)
      check($sformatf("frame_byte%0d_u%0d", i, u), g[i], exp_q[i]);
  endtask

  task automatic wait_ready(input int u);
    int n;
    n = 0;
    while (!cmd_ready[u] && n < 50) begin step(); n++; end
    check("ready_before_cmd", cmd_ready[u], 1);
  endtask

  task automatic run_frame(input int u, input logic [7:0] op, input logic [15:0] len,
                           input logic [31:0] res, input bit bp, output int ncyc);
    bit known;
    known = (op == 8'hEC) || (op == 8'hA0) || (op == 8'hA1) || (op == 8'hA2);
    got0.delete(); got1.delete(); exp_q.delete();
    add_exp((u == 0) ? 1 : 0, op, len, res);
    if (u == 0 && op == 8'hEC) echo_q = pay_q;
    bp_en[u] = bp;
    wait_ready(u);
    cmd_valid[u] = 1'b1; cmd_opcode[u] = op; cmd_len[u] = len; cmd_result[u] = res;
    step();
    cmd_valid[u] = 1'b0;
    check("first_valid", tx_valid[u], exp_q.size() > 0);
    check("bad_op_pulse", bad_op[u], !known);
    check("busy_after_accept", busy[u], known);
    ncyc = 0;
    while (busy[u] && ncyc < 3000) begin step(); ncyc++; end
    check("frame_done", busy[u], 0);
    step();
    check("bad_op_single", bad_op[u], 0);
    check("ready_after_frame", cmd_ready[u], 1);
    bp_en[u] = 1'b0;
    compare_q(u);
  endtask

  // Echo source and tx backpressure, updated just after each clock edge.
  initial begin
    echo_valid0 = 1'b0; echo_data0 = 8'h00;
    echo_valid1 = 1'b0; echo_data1 = 8'h00;
    tx_ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      if (efire) begin
        if (echo_q.size() > 0) void'(echo_q.pop_front());
        efire = 1'b0;
      end
      echo_valid0 = (echo_q.size() > 0);
      echo_data0  = (echo_q.size() > 0) ? echo_q[0] : 8'h00;
      for (int k = 0; k < 2; k++) tx_ready[k] = bp_en[k] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        check("hold_valid_u0", tx_valid[0], 1);
        check("hold_data_u0", tx_data0, hold0);
      end
      if (tx_valid[0] && tx_ready[0]) got0.push_back(tx_data0);
      if (echo_valid0 && echo_ready[0]) efire = 1'b1;
      stall0 = tx_valid[0] && !tx_ready[0];
      hold0  = tx_data0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall1 = 1'b0;
    end else begin
      if (stall1) begin
        check("hold_valid_u1", tx_valid[1], 1);
        check("hold_data_u1", tx_data1, hold1);
      end
      if (tx_valid[1] && tx_ready[1]) got1.push_back(tx_data1);
      stall1 = tx_valid[1] && !tx_ready[1];
      hold1  = tx_data1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, u, pick;
    logic [7:0]  op;
    logic [15:0] len;
    logic [31:0] res;

    rst = 1'b1; cmd_valid = 2'b00; bp_en = 2'b00; efire = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cmd_opcode[k] = 8'h00; cmd_len[k] = 16'd0; cmd_result[k] = 32'd0;
    end
    repeat (3) step();
    check("rst_cmd_ready", cmd_ready, 2'b00);
    check("rst_tx_valid", tx_valid, 2'b00);
    check("rst_tx_data0", tx_data0, 8'h00);
    check("rst_tx_data1", tx_data1, 8'h00);
    check("rst_echo_ready", echo_ready, 2'b00);
    check("rst_busy", busy, 2'b00);
    check("rst_bad_op", bad_op, 2'b00);
    rst = 1'b0;
    step();
    check("post_rst_ready", cmd_ready, 2'b11);

    // Echo "hi" with header; busy for exactly six byte cycles.
    pay_q = '{8'h68, 8'h69};
    run_frame(0, OP_ECHO, 16'd2, 32'd0, 1'b0, n);
    check("hi_busy_cycles", n, 6);

    run_frame(0, OP_ADD, 16'd0, 32'h5, 1'b0, n);
    check("add_busy_cycles", n, 8);

    run_frame(0, OP_MUL, 16'h1234, 32'd24, 1'b1, n);

    // DIV then ADD back-to-back on the payload-only instance.
    got1.delete(); exp_q.delete();
    add_exp(0, OP_DIV, 16'd0, 32'd3);
    add_exp(0, OP_ADD, 16'd0, 32'h12);
    wait_ready(1);
    cmd_valid[1] = 1'b1; cmd_opcode[1] = OP_DIV; cmd_result[1] = 32'd3;
    step();
    cmd_opcode[1] = OP_ADD; cmd_result[1] = 32'h12;
    n = 0;
    while (!cmd_ready[1] && n < 20) begin step(); n++; end
    check("b2b_ready_gap", n, 4);
    step();
    cmd_valid[1] = 1'b0;
    check("b2b_second_busy", busy[1], 1);
    n = 0;
    while (busy[1] && n < 50) begin step(); n++; end
    check("b2b_done", busy[1], 0);
    compare_q(1);

    run_frame(0, 8'h55, 16'd3, 32'hDEAD, 1'b0, n);
    run_frame(1, OP_ECHO, 16'd0, 32'd0, 1'b0, n);
    check("zero_echo_raw_cycles", n, 1);
    run_frame(0, OP_ECHO, 16'd0, 32'd0, 1'b0, n);

    // Reset in the middle of a 10-byte echo.
    pay_q.delete();
    for (int i = 0; i < 10; i++) pay_q.push_back(8'($urandom));
    echo_q = pay_q;
    got0.delete();
    wait_ready(0);
    cmd_valid[0] = 1'b1; cmd_opcode[0] = OP_ECHO; cmd_len[0] = 16'd10;
    step();
    cmd_valid[0] = 1'b0;
    n = 0;
    while (got0.size() < 3 && n < 100) begin step(); n++; end
    check("rst_reach3", got0.size(), 3);
    rst = 1'b1;
    #1;
    check("midrst_tx_valid", tx_valid[0], 0);
    check("midrst_busy", busy[0], 0);
    check("midrst_cmd_ready", cmd_ready[0], 0);
    check("midrst_echo_ready", echo_ready[0], 0);
    echo_q.delete();
    step(); step();
    check("midrst_no_more_bytes", got0.size(), 3);
    rst = 1'b0;
    step();
    run_frame(0, OP_ADD, 16'd0, 32'hCAFE_F00D, 1'b0, n);

    // Randomized frames on both instances.
    for (int k = 0; k < 24; k++) begin
      u    = $urandom_range(0, 1);
      pick = $urandom_range(0, 4);
      res  = $urandom;
      len  = 16'($urandom_range(0, 65535));
      case (pick)
        0: op = OP_ECHO;
        1: op = OP_ADD;
        2: op = OP_MUL;
        3: op = OP_DIV;
        default: begin
          do op = 8'($urandom);
          while (op == 8'hEC || op == 8'hA0 || op == 8'hA1 || op == 8'hA2);
        end
      endcase
      pay_q.delete();
      if (op == OP_ECHO) begin
        len = (u == 0) ? 16'($urandom_range(0, 9)) : 16'd0;
        for (int i = 0; i < int'(len); i++) pay_q.push_back(8'($urandom));
      end
      run_frame(u, op, len, res, 1'($urandom_range(0, 1)), n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_resp_packer.md
Name: uart_resp_packer

Overview:
Return-path framer for the UART ALU. It accepts one completed command from the command parser/ALU: either an echo stream or a 32-bit ALU result. It serializes the response as a byte stream into the UART transmitter's byte interface. It is the outbound counterpart of the inbound packet format [opcode, reserved, len_lsb, len_msb, payload...].

Parameters:
SEND_HEADER, 1, 1 = prefix each response with 4-byte header [opcode, 0x00, len_lsb, len_msb]; 0 = payload only
MAX_LEN, 16'hFFFF, largest legal echo length; a larger cmd_len_i is clamped to MAX_LEN

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-high reset
cmd_valid_i  input  1  command descriptor valid
cmd_ready_o  output  1  packer idle; accepts descriptor
cmd_opcode_i  input  8  0xEC echo, 0xA0 add, 0xA1 mul, 0xA2 div
cmd_len_i  input  16  echo payload byte count; ignored for ALU opcodes
cmd_result_i  input  32  ALU result, sampled at command accept
echo_valid_i  input  1  echo payload byte valid
echo_ready_o  output  1  echo byte consumed this cycle
echo_data_i  input  8  echo payload byte
tx_valid_o  output  1  output byte valid
tx_ready_i  input  1  UART TX accepts byte
tx_data_o  output  8  output byte
busy_o  output  1  response in progress
bad_op_o  output  1  one-cycle pulse on an unsupported opcode

Behaviour:
- Reset (async, rst_i=1):
  - state=IDLE; all counters and holding registers cleared.
  - Outputs: cmd_ready_o=0 while rst_i high, then 1. tx_valid_o=0, tx_data_o=0, echo_ready_o=0, busy_o=0, bad_op_o=0.
- Reset mid-response: the frame is abandoned immediately and no further bytes are emitted. Upstream must also reset.
- Handshakes: all are valid/ready. A transfer occurs on a rising edge when both are high. Once tx_valid_o is asserted, tx_data_o holds stable until tx_ready_i.
- Command accept: a command is accepted on the IDLE cycle with cmd_valid_i=1. It latches opcode, len and result.
  - For ALU opcodes, length is forced to 4.
  - An unknown opcode pulses bad_op_o the next cycle, emits nothing, and stays in IDLE.
- States:
  - IDLE -> HDR if SEND_HEADER, else -> BODY.
  - HDR: emits bytes 0..3 = opcode, 0x00, len[7:0], len[15:8]. A 2-bit index advances per tx handshake. After byte 3: -> BODY, or -> IDLE when len==0.
  - BODY, ALU: emits result little-endian, [7:0] first. After the 4th handshake: -> IDLE.
  - BODY, echo: direct pass-through. tx_valid_o=echo_valid_i, tx_data_o=echo_data_i, echo_ready_o=tx_ready_i, with zero added latency. A 16-bit down-counter decrements per handshake. At 0: -> IDLE, with echo_ready_o deasserted in the same cycle.
  - Echo with len==0 and SEND_HEADER=0: returns to IDLE the cycle after accept, with no bytes emitted.
- Latency: the first tx_valid_o is asserted the cycle after command accept. Throughput is 1 byte/cycle when tx_ready_i is held high.
- busy_o = (state != IDLE). cmd_ready_o = (state == IDLE) && !rst_i.
- Back-to-back: a new command may be accepted on the cycle after the final byte handshake. There are no idle bytes between frames apart from that one cycle.
- Length counter is 16-bit with no wrap; it stops at 0.
- tx_ready_i may toggle arbitrarily; no byte is dropped or duplicated.

Decomposition:
- Shared package uart_alu_pkg:
  - opcode localparams OP_ECHO=8'hEC, OP_ADD=8'hA0, OP_MUL=8'hA1, OP_DIV=8'hA2
  - HDR_BYTES=4, RESULT_BYTES=4
  - enum resp_state_e {IDLE, HDR, BODY}
- No sub-module is needed; the byte mux and counters stay inline. Downstream bit serialization remains in the existing UART TX.

Test Plan:
- Echo "hi": cmd 0xEC, len 2, echo bytes 0x68,0x69, SEND_HEADER=1, tx_ready_i=1 -> tx stream EC 00 02 00 68 69. busy_o falls after the 6th byte.
- ADD result 5: cmd 0xA0, result 32'h5 -> EC-style header A0 00 04 00, then 05 00 00 00.
- MUL 24 with random tx_ready_i backpressure (about 50%) -> A1 00 04 00 18 00 00 00. tx_data_o stays stable while tx_valid_o=1 and tx_ready_i=0.
- DIV 3 then ADD 0x12 back-to-back, SEND_HEADER=0 -> 03 00 00 00 12 00 00 00. The second cmd_ready_o is asserted one cycle after the 4th byte.
- Unknown opcode 0x55 -> bad_op_o single pulse, no tx_valid_o, cmd_ready_o stays 1. Zero-length echo with SEND_HEADER=0 -> no bytes.
- Assert rst_i after the 3rd byte of an echo of length 10 -> tx_valid_o=0 immediately. The next ADD command produces a clean, correct frame.
